dat_mem_stk: RTL and testbench
==============================

Name: dat_mem_stk

Overview:
- Parametrised data memory with a hardware-managed descending stack region.
- Serves the datapath's normal load/store port: combinational read, clocked write.
- Adds single-cycle push/pop with stack-pointer tracking, registered pop data and sticky overflow/underflow/collision flags.
- Sits between the ALU/register file and the control unit's load/store/push/pop decode.

Parameters:
- DW, 8, data word width in bits
- AW, 8, address width; memory depth = 2**AW words
- STACK_TOP, 255, highest address of the stack region; the first push lands here
- STACK_DEPTH, 64, maximum stack entries; legal range 1..STACK_TOP+1

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- addr  in  AW  load/store address
- dat_in  in  DW  store data
- wr_en  in  1  store enable
- dat_out  out  DW  combinational read of core[addr]
- push  in  1  push dat_in onto stack
- pop  in  1  pop top of stack
- pop_data  out  DW  registered popped word
- pop_valid  out  1  one-cycle pulse, pop_data valid
- sp  out  AW  next free stack slot = STACK_TOP - count
- full  out  1  count == STACK_DEPTH
- empty  out  1  count == 0
- clr_err  in  1  synchronous clear of sticky flags
- ovf  out  1  sticky: push while full
- udf  out  1  sticky: pop while empty
- coll  out  1  sticky: wr_en dropped because a stack op occurred in the same cycle

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - count=0, pop_data=0, pop_valid=0, ovf=udf=coll=0.
  - Memory array contents are not reset.
- **Read path**: dat_out = core[addr]; zero latency; also reflects stack contents.
- **Store**: wr_en with no push/pop -> core[addr] <= dat_in at posedge.
- **Stack state**: count register, width clog2(STACK_DEPTH+1).
  - Top-of-stack address T = STACK_TOP - count + 1, valid only when count>0.
- **Push only**, not full:
  - core[STACK_TOP-count] <= dat_in; count++.
- **Pop only**, not empty:
  - pop_data <= core[T]; pop_valid=1 next cycle; count--.
  - The popped slot contents are left unchanged.
- **Push+pop together**, count>0 (replace top):
  - pop_data <= old core[T]; core[T] <= dat_in; count unchanged; pop_valid=1.
  - Legal when full.
- **Push+pop together**, empty:
  - Push proceeds (count becomes 1); pop ignored; udf set; pop_valid stays 0.
- **Push when full** (no pop): ignored, no write, count unchanged, ovf set.
- **Pop when empty** (no push): ignored, udf set, pop_valid 0, pop_data holds previous value.
- **wr_en in the same cycle as any push or pop**: the stack op wins; the store is dropped; coll set. This applies even if the stack op itself was ignored.
- **pop_valid**: high exactly one cycle per successful pop; otherwise 0. pop_data holds its value between pops.
- **Flags**:
  - ovf/udf/coll stay set until clr_err.
  - clr_err in the same cycle as a new error event leaves the flag set (set wins).
- **Reset mid-operation**: any in-flight pop_valid is cleared immediately; the stack is logically emptied; memory keeps its data.
- **Arithmetic**: sp and T are computed modulo 2**AW. Parameter legality guarantees no wrap inside the stack region, so no wrap handling is needed.

Optional Feature:
- **Macro**: DAT_MEM_STACK_PROT_EN.
- **Defined**:
  - Adds output prot_err (1 bit, sticky, reset 0, cleared by clr_err).
  - A wr_en (no stack op) whose addr lies in the occupied range [T .. STACK_TOP], count>0, is suppressed and sets prot_err.
  - Stores to unoccupied stack slots or outside the region proceed normally.
- **Not defined**: no address check; prot_err port exists, tied 0; all such stores write.

Test Plan:
- **Reset then store/load**: rst_n low 2 cycles, release; wr_en addr=0x3C dat_in=0x10 -> dat_out=0x10 with addr=0x3C next cycle; empty=1, sp=0xFF.
- **Push sequence**: push 0xA1, 0xA2, 0xA3 -> core[0xFF]=0xA1, core[0xFE]=0xA2, core[0xFD]=0xA3; sp=0xFC; dat_out at addr 0xFE = 0xA2.
- **Pop sequence**: after the push sequence, pop x3 -> pop_data 0xA3, 0xA2, 0xA1, each with a single-cycle pop_valid one cycle after the pop; empty=1; a 4th pop -> udf=1, pop_valid=0, pop_data stays 0xA1.
- **Replace and full**: STACK_DEPTH=4; push 4 words -> full=1; 5th push -> ovf=1, sp unchanged 0xFB; push+pop with dat_in=0x55 -> pop_data = old top, core[0xFC]=0x55, full stays 1.
- **Collision and flags**: wr_en addr=0x10 with push -> core[0x10] unchanged, coll=1; clr_err -> coll=0; clr_err with a simultaneous pop-on-empty -> udf=1.
- **Protection**:
  - With DAT_MEM_STACK_PROT_EN, 2 entries pushed: wr_en addr=0xFE -> write suppressed, prot_err=1.
  - Same run, wr_en addr=0xFD -> writes.
  - Without the macro, the 0xFE write lands and prot_err=0.

Source files
------------

// File: rtl/dat_mem_stk.sv
// dat_mem_stk: data memory with combinational load port, clocked store port
// and a hardware-managed descending stack (push/pop, sticky error flags).
// Optional store protection of occupied stack slots: DAT_MEM_STACK_PROT_EN.
module dat_mem_stk #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int STACK_TOP   = 255,
  parameter int STACK_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  input  logic          wr_en,
  output logic [DW-1:0] dat_out,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic [AW-1:0] sp,
  output logic          full,
  output logic          empty,
  input  logic          clr_err,
  output logic          ovf,
  output logic          udf,
  output logic          coll,
  output logic          prot_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int XW = AW + 1;

  logic [DW-1:0] core [2**AW];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] top_addr;
  logic          stack_op;
  logic          store_ok;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          pop_take;
  logic          ovf_ev;
  logic          udf_ev;
  logic          coll_ev;

  assign sp       = AW'(STACK_TOP) - AW'(count);
  assign top_addr = sp + AW'(1);
  assign full     = (count == CW'(STACK_DEPTH));
  assign empty    = (count == '0);
  assign stack_op = push | pop;
  assign coll_ev  = wr_en & stack_op;
  assign dat_out  = core[addr];

`ifdef DAT_MEM_STACK_PROT_EN
  logic [AW-1:0] offs;
  logic          prot_hit;

  // Occupied range [T .. STACK_TOP] tested as (addr - T) < count, which
  // avoids a compare against STACK_TOP that may be constant-true.
  assign offs     = addr - top_addr;
  assign prot_hit = !empty && ({1'b0, offs} < XW'(count));
  assign store_ok = wr_en && !stack_op && !prot_hit;

  // Sticky protection flag; a new violation wins over clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prot_err <= 1'b0;
    else        prot_err <= (prot_err & ~clr_err) | (wr_en & ~stack_op & prot_hit);
  end
`else
  assign store_ok = wr_en && !stack_op;
  assign prot_err = 1'b0;
`endif

  // Decode push/pop/store into a single memory write and next stack count
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = dat_in;
    count_nxt = count;
    pop_take  = 1'b0;
    ovf_ev    = 1'b0;
    udf_ev    = 1'b0;
    if (push && pop) begin
      if (empty) begin
        mem_we    = 1'b1;
        mem_waddr = sp;
        count_nxt = count + CW'(1);
        udf_ev    = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = top_addr;
        pop_take  = 1'b1;
      end
    end else if (push) begin
      if (full) begin
        ovf_ev = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = sp;
        count_nxt = count + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        udf_ev = 1'b1;
      end else begin
        pop_take  = 1'b1;
        count_nxt = count - CW'(1);
      end
    end else if (store_ok) begin
      mem_we = 1'b1;
    end
  end

  // Memory array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) core[mem_waddr] <= mem_wdata;
  end

  // Stack count, registered pop data/valid and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      coll      <= 1'b0;
    end else begin
      count     <= count_nxt;
      pop_valid <= pop_take;
      if (pop_take) pop_data <= core[top_addr];
      ovf       <= (ovf  & ~clr_err) | ovf_ev;
      udf       <= (udf  & ~clr_err) | udf_ev;
      coll      <= (coll & ~clr_err) | coll_ev;
    end
  end

endmodule

// File: tb/tb_dat_mem_stk.sv
// tb_dat_mem_stk: directed bench for dat_mem_stk (STACK_DEPTH=4) with a
// pop-data scoreboard queue and immediate-assertion checks.
module tb_dat_mem_stk;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_in;
  logic          wr_en;
  logic [DW-1:0] dat_out;
  logic          push;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic [AW-1:0] sp;
  logic          full;
  logic          empty;
  logic          clr_err;
  logic          ovf;
  logic          udf;
  logic          coll;
  logic          prot_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [DW-1:0] exp_q[$];

  dat_mem_stk #(.DW(DW), .AW(AW), .STACK_TOP(255), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .dat_in(dat_in), .wr_en(wr_en),
    .dat_out(dat_out), .push(push), .pop(pop), .pop_data(pop_data),
    .pop_valid(pop_valid), .sp(sp), .full(full), .empty(empty),
    .clr_err(clr_err), .ovf(ovf), .udf(udf), .coll(coll), .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; pop_valid must match whether a pop result is pending
  task automatic step();
    logic pend;
    @(posedge clk);
    #1;
    pend = (exp_q.size() != 0);
    chk("pop_valid", {15'd0, pop_valid}, {15'd0, pend});
    if (pend) chk("pop_data", {8'd0, pop_data}, {8'd0, exp_q.pop_front()});
  endtask

  task automatic op(input logic p, input logic q, input logic w,
                    input logic [7:0] a, input logic [7:0] d, input logic c);
    push = p; pop = q; wr_en = w; addr = a; dat_in = d; clr_err = c;
    step();
    push = 1'b0; pop = 1'b0; wr_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, {8'd0, dat_out}, {8'd0, exp});
  endtask

  task automatic flags(input logic eo, input logic eu, input logic ec);
    chk("ovf",  {15'd0, ovf},  {15'd0, eo});
    chk("udf",  {15'd0, udf},  {15'd0, eu});
    chk("coll", {15'd0, coll}, {15'd0, ec});
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; wr_en = 1'b0; clr_err = 1'b0;
    addr = '0; dat_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", {15'd0, empty}, 16'd1);
    chk("rst_full", {15'd0, full}, 16'd0);
    chk("rst_sp", {8'd0, sp}, 16'h00FF);
    chk("rst_pop_valid", {15'd0, pop_valid}, 16'd0);
    chk("rst_pop_data", {8'd0, pop_data}, 16'd0);
    chk("rst_prot_err", {15'd0, prot_err}, 16'd0);
    flags(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Plain store / load
    op(1'b0, 1'b0, 1'b1, 8'h3C, 8'h10, 1'b0);
    rd("load_3c", 8'h3C, 8'h10);
    chk("empty_after_store", {15'd0, empty}, 16'd1);
    chk("sp_after_store", {8'd0, sp}, 16'h00FF);

    // Push sequence
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hA1, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hA2, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hA3, 1'b0);
    chk("sp_after_push3", {8'd0, sp}, 16'h00FC);
    rd("core_ff", 8'hFF, 8'hA1);
    rd("core_fe", 8'hFE, 8'hA2);
    rd("core_fd", 8'hFD, 8'hA3);

    // Pop sequence, back to back
    exp_q.push_back(8'hA3); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'hA2); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'hA1); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("empty_after_pop3", {15'd0, empty}, 16'd1);
    op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("pop_data_hold", {8'd0, pop_data}, 16'h00A1);
    flags(1'b0, 1'b1, 1'b0);
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    flags(1'b0, 1'b0, 1'b0);

    // Fill, overflow, replace-top while full
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hB1, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hB2, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hB3, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hB4, 1'b0);
    chk("full_after_4", {15'd0, full}, 16'd1);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hB5, 1'b0);
    chk("sp_after_ovf", {8'd0, sp}, 16'h00FB);
    flags(1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'hB4); op(1'b1, 1'b1, 1'b0, 8'h00, 8'h55, 1'b0);
    chk("full_after_replace", {15'd0, full}, 16'd1);
    rd("core_fc_replaced", 8'hFC, 8'h55);
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    flags(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h55); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'hB3); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'hB2); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'hB1); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("empty_after_drain", {15'd0, empty}, 16'd1);

    // Collision: store dropped when a push happens in the same cycle
    op(1'b0, 1'b0, 1'b1, 8'h10, 8'h77, 1'b0);
    op(1'b1, 1'b0, 1'b1, 8'h10, 8'h99, 1'b0);
    rd("core_10_kept", 8'h10, 8'h77);
    rd("core_ff_pushed", 8'hFF, 8'h99);
    flags(1'b0, 1'b0, 1'b1);
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    flags(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h99); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    flags(1'b0, 1'b1, 1'b0);
    op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Push+pop on empty: push proceeds, pop ignored, udf set
    op(1'b1, 1'b1, 1'b0, 8'h00, 8'h66, 1'b0);
    chk("sp_pushpop_empty", {8'd0, sp}, 16'h00FE);
    flags(1'b0, 1'b1, 1'b0);
    exp_q.push_back(8'h66); op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    flags(1'b0, 1'b0, 1'b0);

    // Protection of occupied stack slots
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hC1, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 8'hC2, 1'b0);
    op(1'b0, 1'b0, 1'b1, 8'hFE, 8'hEE, 1'b0);
`ifdef DAT_MEM_STACK_PROT_EN
    rd("prot_fe_kept", 8'hFE, 8'hC2);
    chk("prot_err_set", {15'd0, prot_err}, 16'd1);
`else
    rd("prot_fe_written", 8'hFE, 8'hEE);
    chk("prot_err_tied", {15'd0, prot_err}, 16'd0);
`endif
    op(1'b0, 1'b0, 1'b1, 8'hFD, 8'hDD, 1'b0);
    rd("free_fd_written", 8'hFD, 8'hDD);
    chk("coll_no_stackop", {15'd0, coll}, 16'd0);

    // Reset in the middle of a pop pulse
    pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
    chk("pv_before_reset", {15'd0, pop_valid}, 16'd1);
`ifdef DAT_MEM_STACK_PROT_EN
    chk("pd_before_reset", {8'd0, pop_data}, 16'h00C2);
`else
    chk("pd_before_reset", {8'd0, pop_data}, 16'h00EE);
`endif
    rst_n = 1'b0;
    #1;
    chk("pv_async_reset", {15'd0, pop_valid}, 16'd0);
    chk("empty_async_reset", {15'd0, empty}, 16'd1);
    chk("sp_async_reset", {8'd0, sp}, 16'h00FF);
    chk("prot_err_reset", {15'd0, prot_err}, 16'd0);
    rd("mem_kept_reset", 8'hFF, 8'hC1);
    rst_n = 1'b1;
    chk("scoreboard_drained", exp_q.size(), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
